// File: rtl/square_seq_cal.sv
// Sequential shift-add squarer: one operand per valid/ready handshake, fixed WIDTH+1 cycle latency.
// Optional saturating sum of delivered squares is built when SQUARE_SUM_EN is defined.
module square_seq_cal #(
  parameter int WIDTH     = 6,
  parameter int SUM_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   square,
  output logic                 busy
`ifdef SQUARE_SUM_EN
  ,
  input  logic                 clr_sum,
  output logic [SUM_WIDTH-1:0] sum_sq
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        count;

  if (WIDTH < 1 || SUM_WIDTH < 1) begin : g_param_check
    $error("square_seq_cal: WIDTH and SUM_WIDTH must be positive");
  end

  // CALC spends WIDTH cycles iterating plus one cycle to publish, so latency is the same for every operand.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      square    <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= {{WIDTH{1'b0}}, value};
            mplier   <= value;
            acc      <= '0;
            count    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          if (count == CW'(WIDTH)) begin
            square    <= acc;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SQUARE_SUM_EN
  localparam int SW = ((SUM_WIDTH > 2*WIDTH) ? SUM_WIDTH : 2*WIDTH) + 1;
  localparam logic [SW-1:0] SUM_MAX = (SW'(1) << SUM_WIDTH) - SW'(1);

  logic [SW-1:0] sum_total;

  // A clear coinciding with a handshake restarts the sum from the square being delivered.
  always_comb begin
    sum_total = (clr_sum ? {SW{1'b0}} : SW'(sum_sq)) + SW'(square);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_sq <= '0;
    end else if (state == DONE && out_valid && out_ready) begin
      sum_sq <= (sum_total > SUM_MAX) ? {SUM_WIDTH{1'b1}} : sum_total[SUM_WIDTH-1:0];
    end else if (clr_sum) begin
      sum_sq <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_square_seq_cal.sv
// Directed bench for square_seq_cal: WIDTH=6 (SUM_WIDTH=12) and WIDTH=8 instances.
// The saturating-sum checks are compiled only when SQUARE_SUM_EN is defined.
module tb_square_seq_cal;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  value = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] square;
  logic        busy;
  logic        clr_sum = 1'b0;
  logic [11:0] sum_sq;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  value8 = '0;
  logic        out_valid8;
  logic        out_ready8 = 1'b0;
  logic [15:0] square8;
  logic        busy8;
  logic        clr_sum8 = 1'b0;
  logic [19:0] sum_sq8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  square_seq_cal #(.WIDTH(6), .SUM_WIDTH(12)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .value(value), .out_valid(out_valid), .out_ready(out_ready),
    .square(square), .busy(busy)
`ifdef SQUARE_SUM_EN
    , .clr_sum(clr_sum), .sum_sq(sum_sq)
`endif
  );

  square_seq_cal #(.WIDTH(8), .SUM_WIDTH(20)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .value(value8), .out_valid(out_valid8), .out_ready(out_ready8),
    .square(square8), .busy(busy8)
`ifdef SQUARE_SUM_EN
    , .clr_sum(clr_sum8), .sum_sq(sum_sq8)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Hands one operand to the 6-bit instance, waits for the result and takes it.
  task automatic applyStimulus(input logic [5:0] v, input logic clr,
                               output logic [11:0] res, output int lat);
    int waited;
    waited = 0;
    while (!in_ready && waited < 30) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    value    = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    if (!out_valid) checkOutput("out_valid_timeout", 32'(out_valid), 32'd1);
    res       = square;
    out_ready = 1'b1;
    clr_sum   = clr;
    @(posedge clk); #1;
    out_ready = 1'b0;
    clr_sum   = 1'b0;
  endtask

  initial begin
    logic [11:0] res;
    int          lat;
    int          k8;

    // Reset state
    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_square", 32'(square), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // value 5: out_valid rises exactly 7 edges after the accept edge
    @(negedge clk);
    in_valid = 1'b1;
    value    = 6'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("t1_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("t1_out_valid_e%0d", k), 32'(out_valid), (k == 7) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t1_in_ready_e%0d", k), 32'(in_ready), 32'd0);
    end
    checkOutput("t1_square", 32'(square), 32'h019);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("t1_out_valid_taken", 32'(out_valid), 32'd0);
    checkOutput("t1_in_ready_taken", 32'(in_ready), 32'd1);
    checkOutput("t1_busy_taken", 32'(busy), 32'd0);

    // Full operand sweep
    for (int v = 0; v < 64; v++) begin
      applyStimulus(6'(v), 1'b0, res, lat);
      checkOutput($sformatf("sweep_%0d", v), 32'(res), 32'(v * v));
      if (v == 0 || v == 63) checkOutput($sformatf("sweep_lat_%0d", v), 32'(lat), 32'd7);
    end
    applyStimulus(6'd63, 1'b0, res, lat);
    checkOutput("max_operand", 32'(res), 32'hF81);

    // Result held under back-pressure while in_valid/value toggle
    in_valid = 1'b1;
    value    = 6'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checkOutput("t3_out_valid", 32'(out_valid), 32'd1);
    for (int c = 0; c < 20; c++) begin
      in_valid = c[0];
      value    = 6'(c * 3 + 1);
      @(posedge clk); #1;
    end
    checkOutput("t3_square_held", 32'(square), 32'h064);
    checkOutput("t3_out_valid_held", 32'(out_valid), 32'd1);
    checkOutput("t3_in_ready_held", 32'(in_ready), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("t3_in_ready_after", 32'(in_ready), 32'd1);

    // Reset three cycles into CALC aborts the operation at once
    in_valid = 1'b1;
    value    = 6'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t4_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t4_in_ready", 32'(in_ready), 32'd1);
    checkOutput("t4_busy", 32'(busy), 32'd0);
    checkOutput("t4_square", 32'(square), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(6'd9, 1'b0, res, lat);
    checkOutput("t4_square_9", 32'(res), 32'h051);
    checkOutput("t4_lat_9", 32'(lat), 32'd7);

`ifdef SQUARE_SUM_EN
    // Saturating sum, then clear on the same edge as a handshake
    applyStimulus(6'd63, 1'b1, res, lat);
    checkOutput("t5_sum_first", 32'(sum_sq), 32'hF81);
    applyStimulus(6'd63, 1'b0, res, lat);
    checkOutput("t5_sum_sat", 32'(sum_sq), 32'hFFF);
    applyStimulus(6'd3, 1'b1, res, lat);
    checkOutput("t5_sum_clr_add", 32'(sum_sq), 32'h009);
`endif

    // WIDTH=8 instance: max operand, 9-edge latency
    @(negedge clk);
    in_valid8 = 1'b1;
    value8    = 8'hFF;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    k8 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid8) begin
        k8 = k;
        break;
      end
    end
    checkOutput("t6_lat", 32'(k8), 32'd9);
    checkOutput("t6_square", 32'(square8), 32'hFE01);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    checkOutput("t6_in_ready", 32'(in_ready8), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
